l2_rx_mc: RTL and testbench

//  Next-generation L2 receive deframer: pops L2 frames (header word, L3 command word, payload) from the RX FIFO.

---
 rtl/l2_rx_mc_if.sv | 35 +++
 rtl/l2_rx_mc.sv | 246 ++++++++++++++++++++++++
 tb/tb_l2_rx_mc.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/l2_rx_mc_if.sv
// RX FIFO and L3 channel bus of the L2 receive deframer.
// master: deframer side; slave: FIFO / L3 engine side.
interface l2_rx_mc_if #(
  parameter int DW  = 32,
  parameter int NCH = 4
);
  localparam int BW = DW / 8;

  logic            rx_fifo_empty;
  logic [DW-1:0]   rx_fifo_dout;
  logic            rx_fifo_rd;
  logic [NCH-1:0]  l3_en;
  logic [3:0]      l3_sel;
  logic [3:0]      l3_id;
  logic [7:0]      l3_op;
  logic [15:0]     l3_extend;
  logic [15:0]     l3_size;
  logic [NCH-1:0]  l3_cmd_done;
  logic [DW-1:0]   l3_wd;
  logic [BW-1:0]   l3_wstrb;
  logic            l3_wd_vld;
  logic            l3_wd_rdy;

  modport master (
    input  rx_fifo_empty, rx_fifo_dout, l3_cmd_done, l3_wd_rdy,
    output rx_fifo_rd, l3_en, l3_sel, l3_id, l3_op, l3_extend, l3_size,
           l3_wd, l3_wstrb, l3_wd_vld
  );

  modport slave (
    output rx_fifo_empty, rx_fifo_dout, l3_cmd_done, l3_wd_rdy,
    input  rx_fifo_rd, l3_en, l3_sel, l3_id, l3_op, l3_extend, l3_size,
           l3_wd, l3_wstrb, l3_wd_vld
  );
endinterface

// File: rtl/l2_rx_mc.sv
// L2 receive deframer: pops header/command/payload words from the RX FIFO,
// starts the selected L3 channel and streams the byte-reversed payload
// through a 2-entry output buffer.
module l2_rx_mc #(
  parameter int DW  = 32,
  parameter int NCH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pin_l2_clr,
  input  logic        pin_l2_loop,
  l2_rx_mc_if.master  bus,
  output logic        l2_err,
  output logic [1:0]  l2_err_code,
  output logic [15:0] frm_cnt
);
  localparam int BW = DW / 8;
  localparam int LB = $clog2(BW);
  localparam logic [15:0] BW16  = 16'(BW);
  localparam logic [LB:0] BW_NB = (LB + 1)'(BW);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_HEAD = 3'd1, S_CMD_RD = 3'd2, S_CMD = 3'd3,
    S_START = 3'd4, S_DATA = 3'd5, S_CLEAN = 3'd6
  } state_t;

  // Byte-reverse a FIFO word (first frame byte to MSB), zeroing bytes past nb.
  function automatic logic [DW-1:0] swap_mask(input logic [DW-1:0] w, input logic [LB:0] nb);
    logic [DW-1:0] r;
    r = '0;
    for (int j = 0; j < BW; j++) begin
      if (j < int'(nb)) r[8*(BW-1-j) +: 8] = w[8*j +: 8];
      else              r[8*(BW-1-j) +: 8] = 8'h00;
    end
    return r;
  endfunction

  // Strobe matching swap_mask: the nb most significant bytes are valid.
  function automatic logic [BW-1:0] strb_of(input logic [LB:0] nb);
    logic [BW-1:0] s;
    s = '0;
    for (int j = 0; j < BW; j++) begin
      if (j < int'(nb)) s[BW-1-j] = 1'b1;
      else              s[BW-1-j] = 1'b0;
    end
    return s;
  endfunction

  state_t          state_r, state_nx_s;
  logic [15:0]     len_r, len_nx_s, len_base_s, hdr_len_s;
  logic            infl_r, infl_last_r;
  logic [1:0]      cnt_r;
  logic [DW-1:0]   d0_r, d1_r, new_d_s;
  logic [BW-1:0]   s0_r, s1_r, new_s_s;
  logic [LB:0]     nb_s;
  logic [3:0]      sel_r, id_r, cmd_sel_s;
  logic [7:0]      op_r;
  logic [15:0]     ext_r, size_r, frm_r;
  logic [NCH-1:0]  sel_oh_r, en_r, cmd_oh_s;
  logic            err_r, err_set_s, rd_s, frm_inc_s, flush_s;
  logic            pop_s, push_s, done_s, drained_s, sel_bad_s;
  logic [1:0]      err_code_r, err_code_s;
  logic [2:0]      occ_s;

  // Decode of FIFO word fields, buffer occupancy and channel completion.
  always_comb begin
    hdr_len_s = bus.rx_fifo_dout[31:16];
    cmd_sel_s = bus.rx_fifo_dout[3:0];
    cmd_oh_s  = '0;
    for (int i = 0; i < NCH; i++) cmd_oh_s[i] = (cmd_sel_s == 4'(i));
    sel_bad_s = ({1'b0, cmd_sel_s} >= 5'(NCH));
    pop_s     = (cnt_r != 2'd0) && bus.l3_wd_rdy;
    occ_s     = {1'b0, cnt_r} + {2'b00, infl_r} - {2'b00, pop_s};
    done_s    = |(bus.l3_cmd_done & sel_oh_r);
    drained_s = (len_r == 16'd0) && !infl_r && (cnt_r == {1'b0, pop_s});
    push_s    = infl_r && (state_r == S_DATA);
    if (infl_last_r && (size_r[LB-1:0] != '0)) nb_s = {1'b0, size_r[LB-1:0]};
    else                                       nb_s = BW_NB;
    new_d_s   = swap_mask(bus.rx_fifo_dout, nb_s);
    new_s_s   = strb_of(nb_s);
  end

  // Next-state, FIFO pop and event decisions; abort overrides everything.
  always_comb begin
    state_nx_s = state_r;
    rd_s       = 1'b0;
    err_set_s  = 1'b0;
    err_code_s = 2'd0;
    frm_inc_s  = 1'b0;
    flush_s    = 1'b0;
    if (pin_l2_clr) begin
      state_nx_s = S_IDLE;
      flush_s    = 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (!bus.rx_fifo_empty && !pin_l2_loop) begin
            rd_s = 1'b1; state_nx_s = S_HEAD;
          end else begin
            state_nx_s = S_IDLE;
          end
        end
        S_HEAD: begin
          if (hdr_len_s == 16'd0) begin
            state_nx_s = S_IDLE;
          end else if (hdr_len_s < BW16) begin
            if (!bus.rx_fifo_empty) begin
              rd_s = 1'b1; err_set_s = 1'b1; err_code_s = 2'd1; state_nx_s = S_IDLE;
            end else begin
              state_nx_s = S_HEAD;
            end
          end else begin
            state_nx_s = S_CMD_RD;
          end
        end
        S_CMD_RD: begin
          if (!bus.rx_fifo_empty) begin
            rd_s = 1'b1; state_nx_s = S_CMD;
          end else begin
            state_nx_s = S_CMD_RD;
          end
        end
        S_CMD: begin
          if (sel_bad_s) begin
            err_set_s = 1'b1; err_code_s = 2'd2; state_nx_s = S_CLEAN;
          end else begin
            state_nx_s = S_START;
          end
        end
        S_START: state_nx_s = S_DATA;
        S_DATA: begin
          rd_s = (len_r != 16'd0) && !bus.rx_fifo_empty && (occ_s < 3'd2);
          if (done_s && drained_s) begin
            frm_inc_s = 1'b1; state_nx_s = S_IDLE;
          end else if (done_s) begin
            err_set_s = 1'b1; err_code_s = 2'd3; flush_s = 1'b1; state_nx_s = S_CLEAN;
          end else begin
            state_nx_s = S_DATA;
          end
        end
        S_CLEAN: begin
          if (len_r == 16'd0) begin
            state_nx_s = S_IDLE;
          end else begin
            rd_s = !bus.rx_fifo_empty; state_nx_s = S_CLEAN;
          end
        end
        default: state_nx_s = S_IDLE;
      endcase
    end
  end

  // Remaining-byte counter: loaded from the header, minus BW per later pop.
  always_comb begin
    if (state_r == S_HEAD) len_base_s = hdr_len_s;
    else                   len_base_s = len_r;
    if (rd_s && (state_r != S_IDLE)) begin
      if (len_base_s >= BW16) len_nx_s = len_base_s - BW16;
      else                    len_nx_s = 16'd0;
    end else begin
      len_nx_s = len_base_s;
    end
  end

  // State, length counter and in-flight payload read tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      len_r       <= 16'd0;
      infl_r      <= 1'b0;
      infl_last_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      len_r       <= pin_l2_clr ? 16'd0 : len_nx_s;
      infl_r      <= rd_s && (state_r == S_DATA);
      infl_last_r <= (len_r <= BW16);
    end
  end

  // Two-entry payload buffer; entry 0 is the presented word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 2'd0; d0_r <= '0; d1_r <= '0; s0_r <= '0; s1_r <= '0;
    end else if (flush_s) begin
      cnt_r <= 2'd0; d0_r <= '0; d1_r <= '0; s0_r <= '0; s1_r <= '0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (cnt_r == 2'd0) begin d0_r <= new_d_s; s0_r <= new_s_s; end
          else               begin d1_r <= new_d_s; s1_r <= new_s_s; end
          cnt_r <= cnt_r + 2'd1;
        end
        2'b01: begin
          if (cnt_r == 2'd2) begin d0_r <= d1_r; s0_r <= s1_r; end
          else               begin d0_r <= '0;   s0_r <= '0;   end
          d1_r <= '0; s1_r <= '0;
          cnt_r <= cnt_r - 2'd1;
        end
        2'b11: begin
          if (cnt_r == 2'd1) begin
            d0_r <= new_d_s; s0_r <= new_s_s;
          end else begin
            d0_r <= d1_r; s0_r <= s1_r; d1_r <= new_d_s; s1_r <= new_s_s;
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Command fields latched in CMD, channel start pulse, errors and frame count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r <= 4'd0; id_r <= 4'd0; op_r <= 8'd0; ext_r <= 16'd0; size_r <= 16'd0;
      sel_oh_r <= '0; en_r <= '0; err_r <= 1'b0; err_code_r <= 2'd0; frm_r <= 16'd0;
    end else begin
      if ((state_r == S_CMD) && !pin_l2_clr) begin
        sel_r    <= cmd_sel_s;
        id_r     <= bus.rx_fifo_dout[7:4];
        op_r     <= bus.rx_fifo_dout[15:8];
        ext_r    <= bus.rx_fifo_dout[31:16];
        size_r   <= len_r;
        sel_oh_r <= cmd_oh_s;
      end
      if ((state_r == S_CMD) && (state_nx_s == S_START)) en_r <= cmd_oh_s;
      else                                                en_r <= '0;
      err_r <= err_set_s;
      if (err_set_s) err_code_r <= err_code_s;
      if (frm_inc_s) frm_r <= frm_r + 16'd1;
    end
  end

  assign bus.rx_fifo_rd = rd_s;
  assign bus.l3_en      = en_r;
  assign bus.l3_sel     = sel_r;
  assign bus.l3_id      = id_r;
  assign bus.l3_op      = op_r;
  assign bus.l3_extend  = ext_r;
  assign bus.l3_size    = size_r;
  assign bus.l3_wd      = d0_r;
  assign bus.l3_wstrb   = s0_r;
  assign bus.l3_wd_vld  = (cnt_r != 2'd0);
  assign l2_err         = err_r;
  assign l2_err_code    = err_code_r;
  assign frm_cnt        = frm_r;
endmodule

// File: tb/tb_l2_rx_mc.sv
// Directed bench for l2_rx_mc (DW=32, NCH=4) with a small RX FIFO model.
module tb_l2_rx_mc;
  localparam int DW  = 32;
  localparam int NCH = 4;

  logic clk = 1'b0, rst_n = 1'b0, pin_l2_clr = 1'b0, pin_l2_loop = 1'b0;
  logic l2_err;
  logic [1:0] l2_err_code;
  logic [15:0] frm_cnt;
  logic [3:0] done_v = 4'h0;
  logic rdy_v = 1'b0;

  l2_rx_mc_if #(.DW(DW), .NCH(NCH)) bus ();

  l2_rx_mc #(.DW(DW), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .pin_l2_clr(pin_l2_clr), .pin_l2_loop(pin_l2_loop),
    .bus(bus), .l2_err(l2_err), .l2_err_code(l2_err_code), .frm_cnt(frm_cnt)
  );

  always #5 clk = ~clk;

  // RX FIFO model: data appears the cycle after a pop and holds until the next pop.
  logic [31:0] mem [0:255];
  int wcnt = 0, rptr = 0;
  logic [31:0] dout_r = 32'h0;
  always @(posedge clk) begin
    if (bus.rx_fifo_rd) begin
      dout_r <= mem[rptr];
      rptr   <= rptr + 1;
    end
  end
  assign bus.rx_fifo_empty = (rptr >= wcnt);
  assign bus.rx_fifo_dout  = dout_r;
  assign bus.l3_cmd_done   = done_v;
  assign bus.l3_wd_rdy     = rdy_v;

  // Monitor, sampled 1 time unit before each rising edge.
  int ncyc = 0, nbeat = 0, n_en = 0, n_err = 0, n_rd = 0, n_bad_rd = 0;
  logic [31:0] bd [0:63];
  logic [3:0]  bs [0:63];
  int          bc [0:63];
  logic [3:0]  last_en = 4'h0;
  always @(negedge clk) begin
    #4;
    ncyc++;
    if (bus.l3_wd_vld === 1'b1 && bus.l3_wd_rdy === 1'b1 && nbeat < 64) begin
      bd[nbeat] = bus.l3_wd; bs[nbeat] = bus.l3_wstrb; bc[nbeat] = ncyc; nbeat++;
    end
    if (bus.l3_en !== 4'h0 && rst_n) begin n_en++; last_en = bus.l3_en; end
    if (l2_err === 1'b1) n_err++;
    if (bus.rx_fifo_rd === 1'b1) begin
      n_rd++;
      if (bus.rx_fifo_empty) n_bad_rd++;
    end
  end

  int nchk = 0, nfail = 0;
  int e0, r0, en0, b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wcnt] = w;
    wcnt++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_beats(input int target);
    for (int i = 0; i < 200 && nbeat < target; i++) @(negedge clk);
  endtask

  task automatic pulse_done(input logic [3:0] d);
    done_v = d;
    @(negedge clk);
    done_v = 4'h0;
  endtask

  initial begin
    // reset values
    cyc(2);
    chk("rst_vld", {31'h0, bus.l3_wd_vld}, 32'h0);
    chk("rst_en", {28'h0, bus.l3_en}, 32'h0);
    chk("rst_err", {31'h0, l2_err}, 32'h0);
    chk("rst_code", {30'h0, l2_err_code}, 32'h0);
    chk("rst_frm", {16'h0, frm_cnt}, 32'h0);
    chk("rst_size", {16'h0, bus.l3_size}, 32'h0);
    chk("rst_wd", bus.l3_wd, 32'h0);
    chk("rst_rd", {31'h0, bus.rx_fifo_rd}, 32'h0);
    rst_n = 1'b1;
    cyc(2);

    // 1: LEN=12, sel=2, two full payload words
    rdy_v = 1'b1;
    push(32'h000C_0000); push(32'h1234_5A12); push(32'h4433_2211); push(32'h8877_6655);
    wait_beats(2);
    chk("t1_nbeat", nbeat, 32'd2);
    chk("t1_en", {28'h0, last_en}, 32'h4);
    chk("t1_size", {16'h0, bus.l3_size}, 32'd8);
    chk("t1_op", {24'h0, bus.l3_op}, 32'h5A);
    chk("t1_id", {28'h0, bus.l3_id}, 32'h1);
    chk("t1_ext", {16'h0, bus.l3_extend}, 32'h1234);
    chk("t1_wd0", bd[0], 32'h1122_3344);
    chk("t1_st0", {28'h0, bs[0]}, 32'hF);
    chk("t1_wd1", bd[1], 32'h5566_7788);
    chk("t1_st1", {28'h0, bs[1]}, 32'hF);
    cyc(1);
    pulse_done(4'b0100);
    cyc(1);
    chk("t1_frm", {16'h0, frm_cnt}, 32'd1);
    chk("t1_nen", n_en, 32'd1);

    // 2: LEN=10, partial last word
    push(32'h000A_0000); push(32'h0000_3301); push(32'hDDCC_BBAA); push(32'h5678_FFEE);
    wait_beats(4);
    chk("t2_size", {16'h0, bus.l3_size}, 32'd6);
    chk("t2_en", {28'h0, last_en}, 32'h2);
    chk("t2_wd0", bd[2], 32'hAABB_CCDD);
    chk("t2_st0", {28'h0, bs[2]}, 32'hF);
    chk("t2_wd1", bd[3], 32'hEEFF_0000);
    chk("t2_st1", {28'h0, bs[3]}, 32'hC);
    pulse_done(4'b0010);
    cyc(1);
    chk("t2_frm", {16'h0, frm_cnt}, 32'd2);

    // 3: 16-word payload at full rate
    push(32'h0044_0000); push(32'h0000_7703);
    for (int i = 0; i < 16; i++) push(32'hA0B0_C000 | 32'(i));
    wait_beats(20);
    chk("t3_nbeat", nbeat, 32'd20);
    chk("t3_span", bc[19] - bc[4], 32'd15);
    chk("t3_size", {16'h0, bus.l3_size}, 32'd64);
    for (int i = 0; i < 16; i++) begin
      chk("t3_wd", bd[4+i], {8'(i), 24'hC0B0A0});
      chk("t3_st", {28'h0, bs[4+i]}, 32'hF);
    end
    pulse_done(4'b1000);
    cyc(1);
    chk("t3_frm", {16'h0, frm_cnt}, 32'd3);
    chk("t3_nbeat_end", nbeat, 32'd20);

    // 4: short frame then empty frame
    e0 = n_err; r0 = n_rd; en0 = n_en;
    push(32'h0002_0000); push(32'hDEAD_BEEF);
    cyc(6);
    chk("t4_rd", n_rd - r0, 32'd2);
    chk("t4_nerr", n_err - e0, 32'd1);
    chk("t4_code", {30'h0, l2_err_code}, 32'd1);
    chk("t4_errlow", {31'h0, l2_err}, 32'h0);
    chk("t4_noen", n_en - en0, 32'd0);
    r0 = n_rd;
    push(32'h0000_0000);
    cyc(5);
    chk("t4_rd0", n_rd - r0, 32'd1);
    chk("t4_nerr0", n_err - e0, 32'd1);
    chk("t4_frm", {16'h0, frm_cnt}, 32'd3);

    // 5a: bad channel select, payload drained
    e0 = n_err; r0 = n_rd; en0 = n_en;
    push(32'h000C_0000); push(32'h0000_0007); push(32'h1111_1111); push(32'h2222_2222);
    cyc(10);
    chk("t5a_rd", n_rd - r0, 32'd4);
    chk("t5a_nerr", n_err - e0, 32'd1);
    chk("t5a_code", {30'h0, l2_err_code}, 32'd2);
    chk("t5a_noen", n_en - en0, 32'd0);
    chk("t5a_sel", {28'h0, bus.l3_sel}, 32'd7);
    chk("t5a_nbeat", nbeat, 32'd20);

    // 5b: early done on ch1 after one beat
    e0 = n_err; r0 = n_rd; b0 = nbeat;
    rdy_v = 1'b1;
    push(32'h0014_0000); push(32'h0000_0101);
    push(32'h3132_3334); push(32'h4142_4344); push(32'h5152_5354); push(32'h6162_6364);
    wait_beats(b0 + 1);
    rdy_v = 1'b0;
    cyc(1);
    pulse_done(4'b0001);
    cyc(1);
    chk("t5b_other_ch", n_err - e0, 32'd0);
    pulse_done(4'b0010);
    cyc(6);
    chk("t5b_nerr", n_err - e0, 32'd1);
    chk("t5b_code", {30'h0, l2_err_code}, 32'd3);
    chk("t5b_rd", n_rd - r0, 32'd6);
    chk("t5b_nbeat", nbeat - b0, 32'd1);
    chk("t5b_wd0", bd[b0], 32'h3433_3231);
    chk("t5b_vld", {31'h0, bus.l3_wd_vld}, 32'h0);
    chk("t5b_size", {16'h0, bus.l3_size}, 32'd16);
    chk("t5b_frm", {16'h0, frm_cnt}, 32'd3);

    // 6: abort with valid payload, then loop-back hold
    e0 = n_err;
    push(32'h000C_0000); push(32'h00AB_0000); push(32'h7777_7777); push(32'h8888_8888);
    for (int i = 0; i < 50 && bus.l3_wd_vld !== 1'b1; i++) @(negedge clk);
    chk("t6_vld_pre", {31'h0, bus.l3_wd_vld}, 32'h1);
    pin_l2_clr = 1'b1;
    @(negedge clk);
    pin_l2_clr = 1'b0;
    chk("t6_vld", {31'h0, bus.l3_wd_vld}, 32'h0);
    chk("t6_en", {28'h0, bus.l3_en}, 32'h0);
    chk("t6_err", {31'h0, l2_err}, 32'h0);
    chk("t6_frm", {16'h0, frm_cnt}, 32'd3);
    chk("t6_code", {30'h0, l2_err_code}, 32'd3);
    chk("t6_ext", {16'h0, bus.l3_extend}, 32'h00AB);
    pin_l2_loop = 1'b1;
    r0 = n_rd;
    push(32'h0000_0000);
    cyc(5);
    chk("t6_loop_rd", n_rd - r0, 32'd0);
    pin_l2_loop = 1'b0;
    cyc(4);
    chk("t6_idle_rd", n_rd - r0, 32'd1);
    chk("t6_nerr", n_err - e0, 32'd0);
    chk("bad_rd", n_bad_rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  // Overall time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
